cacheline_adaptor: RTL and testbench
====================================

Name: cacheline_adaptor

Overview:
- Sits directly downstream of the I/D memory arbiter. Takes its 256-bit cacheline read/write requests and converts them into 4-beat 64-bit bursts on the physical memory bus.
- Upstream, it returns a single-cycle response once the whole line has transferred.
- Latches the request at acceptance, so later changes on the upstream inputs cannot corrupt an in-flight burst.

Parameters:
- LINE_W, 256, cacheline width in bits.
- BURST_W, 64, memory bus beat width in bits.
- Derived, not overridable: BEATS = LINE_W/BURST_W (4); OFF_W = log2(LINE_W/8) (5).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- line_i  input  256  write line from arbiter.
- line_o  output  256  assembled read line to arbiter.
- address_i  input  32  request address.
- read_i  input  1  line read request (level).
- write_i  input  1  line write request (level).
- resp_o  output  1  line done, 1-cycle pulse.
- burst_i  input  64  read beat from memory.
- burst_o  output  64  write beat to memory.
- address_o  output  32  line-aligned burst address.
- read_o  output  1  burst read request.
- write_o  output  1  burst write request.
- resp_i  input  1  memory beat acknowledge (one beat per high cycle).
- perf_rd_cnt_o  output  32  completed read bursts (optional feature).
- perf_wr_cnt_o  output  32  completed write bursts (optional feature).

Behaviour:
- Reset (rst_n low, asynchronous, any state, including mid-burst):
  - State goes to IDLE; beat counter goes to 0.
  - line_o, burst_o, address_o, read_o, write_o, resp_o and the perf counters all go to 0.
  - The line buffer is cleared.
  - An aborted burst is dropped; nothing is replayed after reset.
- Clock and reset ports use the codebase names clk / rst_n; reset is asynchronous, active-low.
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE:
  - read_i high: latch {address_i[31:OFF_W], OFF_W'b0} into the address register, clear the counter, go to READ.
  - Else write_i high: latch the address and line_i into the buffer, clear the counter, go to WRITE.
  - read_i and write_i both high: read wins; write_i is ignored for this transaction.
- READ:
  - read_o = 1; address_o = latched address.
  - Each cycle with resp_i high: buffer[cnt*64 +: 64] <= burst_i; cnt increments.
  - On the resp_i cycle with cnt == BEATS-1, go to DONE.
  - Beats need not be consecutive; resp_i-low cycles stall without side effects.
- WRITE:
  - write_o = 1; address_o = latched address; burst_o = buffer[cnt*64 +: 64] (combinational from cnt).
  - Advance on resp_i exactly as in READ; the fourth resp_i goes to DONE.
- DONE:
  - resp_o = 1 for exactly this one cycle; read_o and write_o are 0; next state is IDLE.
  - read_i/write_i are not sampled in DONE. A request still held here is accepted in the following IDLE cycle.
- Latency:
  - First memory request is asserted the cycle after acceptance.
  - resp_o rises the cycle after the 4th resp_i.
  - Minimum line time is 6 cycles: 1 accept + 4 beats + 1 done.
- line_o:
  - Always driven from the buffer; valid during resp_o for reads.
  - Holds that value until the next accepted read begins overwriting it.
  - After a write, line_o shows the written line.
- Upstream inputs (address_i, line_i, read_i, write_i) are ignored outside IDLE. Deasserting a request mid-burst does not abort it.
- resp_i high in IDLE or DONE is ignored.
- The counter is 2 bits wide; it wraps to 0 on the final beat.

Optional Feature:
- Macro: ADAPTOR_PERF_CNT_EN.
- Defined:
  - perf_rd_cnt_o increments on each READ→DONE transition.
  - perf_wr_cnt_o increments on each WRITE→DONE transition.
  - Both wrap modulo 2^32 and are cleared by reset.
- Undefined: both outputs are tied to 32'b0 and no counter flops are synthesized.

Test Plan:
1. Read: address_i=0x0000_1234, read_i held; memory returns burst_i 0x11..11, 0x22..22, 0x33..33, 0x44..44 on consecutive resp_i -> address_o=0x0000_1220; read_o high for 4 cycles; resp_o pulses 1 cycle later; line_o = {0x44..44, 0x33..33, 0x22..22, 0x11..11}.
2. Write: line_i = {64'hD, 64'hC, 64'hB, 64'hA}, address 0x8000_0040 -> write_o high; burst_o = A, B, C, D on successive resp_i; single resp_o pulse; read_o stays 0.
3. Stalled read: resp_i pattern 1,0,0,1,0,1,1 -> exactly 4 beats captured in order; resp_o only after the 7th cycle; total of 4 buffer updates.
4. Mid-burst change: after beat 2, switch address_i to 0x0000_0100 and raise write_i -> address_o stays latched; read completes unchanged; write accepted only in the cycle after DONE.
5. Simultaneous read_i=write_i=1 in IDLE -> READ taken, write_o never asserted for that transaction.
6. rst_n pulled low after beat 2 of a write -> all outputs 0 immediately (asynchronously); after release, FSM is in IDLE with cnt=0; a new read completes normally. With ADAPTOR_PERF_CNT_EN, the counters read 0 after reset and equal 1/1 after one read and one write.

Source files
------------

// File: rtl/cacheline_adaptor_if.sv
// Bus bundle between the line arbiter, the cacheline adaptor and the 64-bit memory port.
// The slave modport is the adaptor's view; master is the environment (arbiter + memory).
interface cacheline_adaptor_if #(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64
);
  logic [LINE_W-1:0]  line_i;
  logic [LINE_W-1:0]  line_o;
  logic [31:0]        address_i;
  logic               read_i;
  logic               write_i;
  logic               resp_o;
  logic [BURST_W-1:0] burst_i;
  logic [BURST_W-1:0] burst_o;
  logic [31:0]        address_o;
  logic               read_o;
  logic               write_o;
  logic               resp_i;
  logic [31:0]        perf_rd_cnt_o;
  logic [31:0]        perf_wr_cnt_o;

  modport slave (
    input  line_i, address_i, read_i, write_i, burst_i, resp_i,
    output line_o, resp_o, burst_o, address_o, read_o, write_o,
           perf_rd_cnt_o, perf_wr_cnt_o
  );

  modport master (
    output line_i, address_i, read_i, write_i, burst_i, resp_i,
    input  line_o, resp_o, burst_o, address_o, read_o, write_o,
           perf_rd_cnt_o, perf_wr_cnt_o
  );
endinterface

// File: rtl/cacheline_adaptor.sv
// Splits 256-bit line reads/writes into 4 x 64-bit memory beats; resp_o pulses one cycle after the 4th beat.
// Define ADAPTOR_PERF_CNT_EN to build the completed-read/write burst counters (otherwise tied to 0).
module cacheline_adaptor #(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64
) (
  input logic                 clk,
  input logic                 rst_n,
  cacheline_adaptor_if.slave  io_bus
);
  localparam int BEATS = LINE_W / BURST_W;
  localparam int OFF_W = $clog2(LINE_W / 8);
  localparam int CNT_W = $clog2(BEATS);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [LINE_W-1:0] r_buf;
  logic [31:0]       r_addr;
  logic              r_read;
  logic              r_write;
  logic              r_resp;
  logic              w_last;
  logic              w_unused;

  assign w_last   = io_bus.resp_i && (r_cnt == CNT_W'(BEATS - 1));
  assign w_unused = ^io_bus.address_i[OFF_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_buf   <= '0;
      r_addr  <= '0;
      r_read  <= 1'b0;
      r_write <= 1'b0;
      r_resp  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          // Read has priority when both requests are raised together.
          if (io_bus.read_i) begin
            r_addr  <= {io_bus.address_i[31:OFF_W], {OFF_W{1'b0}}};
            r_cnt   <= '0;
            r_read  <= 1'b1;
            r_state <= READ;
          end else if (io_bus.write_i) begin
            r_addr  <= {io_bus.address_i[31:OFF_W], {OFF_W{1'b0}}};
            r_buf   <= io_bus.line_i;
            r_cnt   <= '0;
            r_write <= 1'b1;
            r_state <= WRITE;
          end
        end
        READ: begin
          if (io_bus.resp_i) begin
            r_buf[r_cnt*BURST_W +: BURST_W] <= io_bus.burst_i;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) begin
              r_read  <= 1'b0;
              r_resp  <= 1'b1;
              r_state <= DONE;
            end
          end
        end
        WRITE: begin
          if (io_bus.resp_i) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) begin
              r_write <= 1'b0;
              r_resp  <= 1'b1;
              r_state <= DONE;
            end
          end
        end
        DONE: begin
          r_resp  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign io_bus.line_o    = r_buf;
  assign io_bus.burst_o   = r_buf[r_cnt*BURST_W +: BURST_W];
  assign io_bus.address_o = r_addr;
  assign io_bus.read_o    = r_read;
  assign io_bus.write_o   = r_write;
  assign io_bus.resp_o    = r_resp;

`ifdef ADAPTOR_PERF_CNT_EN
  logic [31:0] r_perf_rd;
  logic [31:0] r_perf_wr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_rd <= '0;
      r_perf_wr <= '0;
    end else begin
      if (r_state == READ && w_last) r_perf_rd <= r_perf_rd + 32'd1;
      if (r_state == WRITE && w_last) r_perf_wr <= r_perf_wr + 32'd1;
    end
  end

  assign io_bus.perf_rd_cnt_o = r_perf_rd;
  assign io_bus.perf_wr_cnt_o = r_perf_wr;
`else
  assign io_bus.perf_rd_cnt_o = 32'b0;
  assign io_bus.perf_wr_cnt_o = 32'b0;
`endif
endmodule

// File: tb/tb_cacheline_adaptor.sv
// Table-driven line transactions against a scoreboard, plus hand sequences for mid-burst input changes and reset abort.
module tb_cacheline_adaptor;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  cacheline_adaptor_if bus ();

  cacheline_adaptor dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             rd;
    logic             wr;
    logic [31:0]      addr;
    logic [255:0]     line;
    logic [3:0][63:0] beats;
    logic [7:0]       pat;
    int               lat;
    logic [31:0]      exp_addr;
  } vec_t;

  typedef struct {
    logic [255:0] line;
    logic [31:0]  addr;
    logic         is_read;
    int           lat;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[5];
  vec_t vm_r, vm_w, vr_w;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input vec_t v);
    exp_t e;
    e.line    = v.rd ? 256'(v.beats) : v.line;
    e.addr    = v.exp_addr;
    e.is_read = v.rd;
    e.lat     = v.lat;
    sb.push_back(e);
  endtask

  // Called one sample after acceptance; plays the memory side until resp_o.
  task automatic drain(input vec_t v);
    int   k, rd_cyc, wr_cyc;
    bit   done;
    logic r;
    exp_t e;
    k = 0; rd_cyc = 0; wr_cyc = 0; done = 0;
    for (int c = 0; c < 64 && !done; c++) begin
      if (bus.resp_o === 1'b1) begin
        done = 1;
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("line_o", bus.line_o, e.line);
          check("done_address_o", bus.address_o, e.addr);
          check("resp_latency", c, e.lat);
          check("beat_count", k, 4);
          check("read_o_cycles", rd_cyc, e.is_read ? e.lat : 0);
          check("write_o_cycles", wr_cyc, e.is_read ? 0 : e.lat);
          check("req_in_done", {bus.read_o, bus.write_o}, 2'b00);
        end
        bus.read_i  = 1'b0;
        bus.write_i = 1'b0;
        bus.resp_i  = 1'b0;
      end else begin
        if (c == 0) check("burst_address_o", bus.address_o, v.exp_addr);
        if (bus.read_o === 1'b1) rd_cyc++;
        if (bus.write_o === 1'b1) wr_cyc++;
        r = (c < 8) ? v.pat[c] : 1'b1;
        bus.resp_i = r;
        if (r && k < 4) begin
          if (bus.read_o === 1'b1) bus.burst_i = v.beats[k];
          if (bus.write_o === 1'b1) check("burst_o", bus.burst_o, v.line[k*64 +: 64]);
          k++;
        end
      end
      step();
    end
    if (!done) check("resp_o_timeout", bus.resp_o, 1'b1);
    else check("resp_o_pulse_width", bus.resp_o, 1'b0);
  endtask

  task automatic run_vec(input vec_t v);
    bus.read_i    = v.rd;
    bus.write_i   = v.wr;
    bus.address_i = v.addr;
    bus.line_i    = v.line;
    push_exp(v);
    step();
    drain(v);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_ctrl"}, {bus.read_o, bus.write_o, bus.resp_o}, 3'b000);
    check({name, "_address_o"}, bus.address_o, 32'h0);
    check({name, "_burst_o"}, bus.burst_o, 64'h0);
    check({name, "_line_o"}, bus.line_o, 256'h0);
    check({name, "_perf"}, {bus.perf_rd_cnt_o, bus.perf_wr_cnt_o}, 64'h0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    vecs[0] = '{rd: 1'b1, wr: 1'b0, addr: 32'h0000_1234, line: 256'h0,
                beats: {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                        64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
                pat: 8'hFF, lat: 4, exp_addr: 32'h0000_1220};
    vecs[1] = '{rd: 1'b0, wr: 1'b1, addr: 32'h8000_0040,
                line: {64'hD, 64'hC, 64'hB, 64'hA}, beats: '0,
                pat: 8'hFF, lat: 4, exp_addr: 32'h8000_0040};
    vecs[2] = '{rd: 1'b1, wr: 1'b0, addr: 32'h0000_ABCD, line: 256'h0,
                beats: {64'hDEAD_BEEF_0000_0004, 64'hDEAD_BEEF_0000_0003,
                        64'hDEAD_BEEF_0000_0002, 64'hDEAD_BEEF_0000_0001},
                pat: 8'h69, lat: 7, exp_addr: 32'h0000_ABC0};
    vecs[3] = '{rd: 1'b1, wr: 1'b1, addr: 32'h0000_0047,
                line: {4{64'hBAD0_BAD0_BAD0_BAD0}},
                beats: {64'hA5A5_0000_0000_0003, 64'h5A5A_0000_0000_0002,
                        64'hFFFF_0000_0000_0001, 64'h0123_4567_89AB_CDEF},
                pat: 8'hFF, lat: 4, exp_addr: 32'h0000_0040};
    vecs[4] = '{rd: 1'b0, wr: 1'b1, addr: 32'hFFFF_FFFF,
                line: {64'hCAFE_0000_0000_0003, 64'hCAFE_0000_0000_0002,
                       64'hCAFE_0000_0000_0001, 64'hCAFE_0000_0000_0000},
                beats: '0, pat: 8'h55, lat: 7, exp_addr: 32'hFFFF_FFE0};
    vm_r = '{rd: 1'b1, wr: 1'b0, addr: 32'h0000_0210, line: 256'h0,
             beats: {64'h8, 64'h7, 64'h6, 64'h5}, pat: 8'hFF, lat: 4,
             exp_addr: 32'h0000_0200};
    vm_w = '{rd: 1'b0, wr: 1'b1, addr: 32'h0000_0100,
             line: {64'h1234, 64'h5678, 64'h9ABC, 64'hDEF0}, beats: '0,
             pat: 8'hFF, lat: 4, exp_addr: 32'h0000_0100};
    vr_w = '{rd: 1'b0, wr: 1'b1, addr: 32'h0000_0300,
             line: {4{64'h7777_6666_5555_4444}}, beats: '0,
             pat: 8'hFF, lat: 4, exp_addr: 32'h0000_0300};

    rst_n = 1'b0;
    bus.read_i = 1'b0; bus.write_i = 1'b0; bus.resp_i = 1'b0;
    bus.address_i = '0; bus.line_i = '0; bus.burst_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    step();

    // resp_i in IDLE must not start anything
    bus.resp_i = 1'b1;
    step();
    step();
    check("idle_resp_ignored", {bus.read_o, bus.write_o, bus.resp_o}, 3'b000);
    bus.resp_i = 1'b0;
    step();

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Upstream changes mid-read must not disturb the burst; write waits until after DONE
    bus.read_i = 1'b1; bus.address_i = vm_r.addr;
    push_exp(vm_r);
    step();
    bus.resp_i = 1'b1; bus.burst_i = vm_r.beats[0];
    step();
    bus.burst_i = vm_r.beats[1];
    step();
    bus.read_i = 1'b0; bus.write_i = 1'b1; bus.address_i = vm_w.addr; bus.line_i = vm_w.line;
    bus.burst_i = vm_r.beats[2];
    step();
    check("mid_address_hold", bus.address_o, 32'h0000_0200);
    check("mid_read_o_hold", {bus.read_o, bus.write_o}, 2'b10);
    bus.burst_i = vm_r.beats[3];
    step();
    bus.resp_i = 1'b0;
    check("mid_resp_o", bus.resp_o, 1'b1);
    if (bus.resp_o === 1'b1 && sb.size() != 0) begin
      check("mid_line_o", bus.line_o, sb[0].line);
      void'(sb.pop_front());
    end
    step();
    check("mid_no_early_write", {bus.write_o, bus.resp_o}, 2'b00);
    push_exp(vm_w);
    step();
    bus.write_i = 1'b0;
    check("mid_write_started", bus.write_o, 1'b1);
    drain(vm_w);

    // Asynchronous reset in the middle of a write burst
    bus.write_i = 1'b1; bus.address_i = vr_w.addr; bus.line_i = vr_w.line;
    step();
    bus.write_i = 1'b0;
    bus.resp_i  = 1'b1;
    step();
    step();
    bus.resp_i = 1'b0;
    check("pre_reset_write_o", bus.write_o, 1'b1);
    #1 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    step();
    step();
    rst_n = 1'b1;
    step();
    step();
    check_all_zero("post_reset");

    run_vec(vecs[0]);
    run_vec(vecs[1]);
`ifdef ADAPTOR_PERF_CNT_EN
    check("perf_counts", {bus.perf_rd_cnt_o, bus.perf_wr_cnt_o}, {32'd1, 32'd1});
`else
    check("perf_counts", {bus.perf_rd_cnt_o, bus.perf_wr_cnt_o}, 64'h0);
`endif
    check("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end
endmodule
